startup_display_seq: RTL and testbench

Parametrised startup display sequencer. After reset or a START pulse it steps a pattern address through NPAT patterns. For each address it requests a pattern load over a REQ/ACK handshake, then dwells a programmable number of clocks, then advances. It supports one-shot or continuous looping, a dwell hold, abort, and a pass counter, and ends with the display cleared. It sits between the startup controller and the front-panel/LED pattern ROM loader.

---
 rtl/startup_display_if.sv | 19 +
 rtl/startup_display_seq.sv | 89 ++++++++
 tb/tb_startup_display_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/startup_display_if.sv
// startup_display_if: control/status bundle between the startup controller
// and the display pattern sequencer.
interface startup_display_if #(
    parameter int ADR_W = 4,
    parameter int PASS_W = 8
);
    logic start, loop, hold, abort, load_ack;
    logic load_req, nxt_adr, disp, clear, busy, done;
    logic [ADR_W-1:0] adr;
    logic [PASS_W-1:0] pass_cnt;
    modport slave (
        input start, loop, hold, abort, load_ack,
        output load_req, adr, nxt_adr, disp, clear, busy, done, pass_cnt
    );
    modport master (
        output start, loop, hold, abort, load_ack,
        input load_req, adr, nxt_adr, disp, clear, busy, done, pass_cnt
    );
endinterface

// File: rtl/startup_display_seq.sv
// startup_display_seq: steps a pattern address through NPAT patterns, loading
// each over a req/ack handshake and dwelling DWELL clocks, with loop/hold/abort.
module startup_display_seq #(
    parameter int NPAT = 16,
    parameter int ADR_W = 4,
    parameter int TMR_W = 16,
    parameter int DWELL = 3000,
    parameter int PASS_W = 8,
    parameter bit AUTO_START = 1'b1
) (
    input logic clk,
    input logic rst_n,
    startup_display_if.slave bus
);
    localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(NPAT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL - 1);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_NEXT, S_END} state_t;
    state_t state, nxt;
    logic [ADR_W-1:0] adr, adr_d;
    logic [PASS_W-1:0] pass_cnt, pass_d;
    logic [TMR_W-1:0] tmr, tmr_d;
    logic load_req, nxt_adr, busy, done, last;
    assign last = adr == ADR_LAST;
    always_comb begin
        nxt = state;
        adr_d = adr;
        pass_d = pass_cnt;
        tmr_d = tmr;
        case (state)
            S_IDLE: if (bus.start || AUTO_START) begin
                nxt = S_LOAD;
                adr_d = '0;
                pass_d = '0;
            end
            S_LOAD: if (bus.abort) nxt = S_END;
                else if (bus.load_ack) begin
                    nxt = S_WAIT;
                    tmr_d = '0;
                end
            S_WAIT: if (bus.abort) nxt = S_END;
                else if (!bus.hold) begin
                    nxt = tmr == TMR_LAST ? S_NEXT : S_WAIT;
                    tmr_d = tmr + 1'b1;
                end
            S_NEXT: if (bus.abort) nxt = S_END;
                else begin
                    nxt = (last && !bus.loop) ? S_END : S_LOAD;
                    adr_d = !last ? adr + 1'b1 : bus.loop ? '0 : adr;
                    pass_d = (!last || &pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
                end
            S_END: if (bus.start) begin
                nxt = S_LOAD;
                adr_d = '0;
                pass_d = '0;
            end
            default: nxt = S_IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            adr <= '0;
            pass_cnt <= '0;
            tmr <= '0;
            load_req <= 1'b0;
            nxt_adr <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= nxt;
            adr <= adr_d;
            pass_cnt <= pass_d;
            tmr <= tmr_d;
            load_req <= nxt == S_LOAD;
            nxt_adr <= state == S_NEXT && nxt == S_LOAD;
            busy <= nxt inside {S_LOAD, S_WAIT, S_NEXT};
            done <= nxt == S_END;
        end
    end
    assign bus.load_req = load_req;
    assign bus.adr = adr;
    assign bus.nxt_adr = nxt_adr;
    assign bus.disp = busy;
    assign bus.clear = !busy;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.pass_cnt = pass_cnt;
endmodule

// File: tb/tb_startup_display_seq.sv
// tb_startup_display_seq: table-driven scoreboard bench for startup_display_seq
// (NPAT=3, DWELL=4, PASS_W=2; one auto-start and one manual-start instance).
module tb_startup_display_seq;
    typedef enum int {SI, SL, SW, SN, SE} ph_t;
    typedef struct { logic [4:0] in; logic [12:0] exp; string tag; } vec_t;
    typedef struct { bit sel; logic [12:0] exp; string tag; } sb_t;
    localparam logic [4:0] ACK = 5'b00001, ABT = 5'b00010, HLD = 5'b00100, LP = 5'b01000, ST = 5'b10000;
    logic clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
    int errors = 0, checks = 0;
    vec_t tbl[$];
    sb_t sb[$];
    always #5 clk = ~clk;
    startup_display_if #(.ADR_W(4), .PASS_W(2)) if_a ();
    startup_display_if #(.ADR_W(4), .PASS_W(2)) if_b ();
    startup_display_seq #(.NPAT(3), .ADR_W(4), .TMR_W(16), .DWELL(4), .PASS_W(2), .AUTO_START(1'b1))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a));
    startup_display_seq #(.NPAT(3), .ADR_W(4), .TMR_W(16), .DWELL(4), .PASS_W(2), .AUTO_START(1'b0))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(if_b));
    // Expected output word: {load_req, adr[3:0], nxt_adr, disp, clear, busy, done, pass_cnt[1:0]}
    function automatic logic [12:0] ex(ph_t p, int adr, bit nx, int ps);
        logic b;
        b = p inside {SL, SW, SN};
        return {p == SL, 4'(adr), nx, b, !b, b, p == SE, 2'(ps)};
    endfunction
    function automatic logic [12:0] got(bit sel);
        return sel ? {if_b.load_req, if_b.adr, if_b.nxt_adr, if_b.disp, if_b.clear, if_b.busy, if_b.done, if_b.pass_cnt}
                   : {if_a.load_req, if_a.adr, if_a.nxt_adr, if_a.disp, if_a.clear, if_a.busy, if_a.done, if_a.pass_cnt};
    endfunction
    function automatic void add(string tg, logic [4:0] in, ph_t p, int adr, bit nx, int ps);
        tbl.push_back('{in, ex(p, adr, nx, ps), tg});
    endfunction
    function automatic void gen_pat(string tg, logic [4:0] fi, logic [4:0] in, int adr, bit nx, int ps);
        add(tg, fi, SL, adr, nx, ps);
        for (int k = 0; k < 4; k++) add(tg, in, SW, adr, 1'b0, ps);
        add(tg, in, SN, adr, 1'b0, ps);
    endfunction
    task automatic check(string tag, logic [12:0] g, logic [12:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got req_adr_nxt_disp_clr_busy_done_pass=%b required %b", tag, g, e);
        end
    endtask
    task automatic drive(logic [4:0] in);
        {if_a.start, if_a.loop, if_a.hold, if_a.abort, if_a.load_ack} = in;
        {if_b.start, if_b.loop, if_b.hold, if_b.abort, if_b.load_ack} = in;
    endtask
    task automatic step(bit sel, logic [4:0] in, logic [12:0] e, string tag);
        sb_t s;
        drive(in);
        sb.push_back('{sel, e, tag});
        @(posedge clk);
        #1;
        s = sb.pop_front();
        check(s.tag, got(s.sel), s.exp);
        @(negedge clk);
    endtask
    initial begin
        drive(5'b0);
        #3;
        check("reset_a", got(1'b0), ex(SI, 0, 1'b0, 0));
        check("reset_b", got(1'b1), ex(SI, 0, 1'b0, 0));
        gen_pat("oneshot", ACK, ACK, 0, 1'b0, 0);
        gen_pat("oneshot", ACK, ACK, 1, 1'b1, 0);
        gen_pat("oneshot", ACK, ACK, 2, 1'b1, 0);
        add("oneshot_end", ACK, SE, 2, 1'b0, 1);
        add("oneshot_end", ACK, SE, 2, 1'b0, 1);
        for (int p = 0; p < 5; p++)
            for (int a = 0; a < 3; a++)
                gen_pat("loop", (p == 0 && a == 0) ? (ST | LP | ACK) : (LP | ACK), LP | ACK, a,
                        !(p == 0 && a == 0), p < 3 ? p : 3);
        add("loop_end_sat", ACK, SE, 2, 1'b0, 3);
        add("loop_end_sat", ACK, SE, 2, 1'b0, 3);
        add("ackdly", ST | LP, SL, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++) add("ackdly", LP, SL, 0, 1'b0, 0);
        add("ackdly", LP | ACK, SW, 0, 1'b0, 0);
        for (int k = 0; k < 6; k++) add("hold", (k >= 1 && k <= 3) ? (LP | ACK | HLD) : (LP | ACK), SW, 0, 1'b0, 0);
        add("hold", LP | ACK, SN, 0, 1'b0, 0);
        gen_pat("after_hold", LP | ACK, LP | ACK, 1, 1'b1, 0);
        gen_pat("after_hold", LP | ACK, LP | ACK, 2, 1'b1, 0);
        gen_pat("wrap", LP | ACK, LP | ACK, 0, 1'b1, 1);
        add("abort", LP | ACK, SL, 1, 1'b1, 1);
        add("abort", LP | ACK, SW, 1, 1'b0, 1);
        add("abort", LP | ACK, SW, 1, 1'b0, 1);
        add("abort", LP | ACK | ABT, SE, 1, 1'b0, 1);
        add("abort_in_end", ABT, SE, 1, 1'b0, 1);
        add("start_abort_end", ST | ABT, SL, 0, 1'b0, 0);
        add("abort_in_load", ABT, SE, 0, 1'b0, 0);
        @(negedge clk);
        rst_a = 1'b1;
        foreach (tbl[i]) step(1'b0, tbl[i].in, tbl[i].exp, $sformatf("%s[%0d]", tbl[i].tag, i));
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 5'b0, ex(SI, 0, 1'b0, 0), "b_idle");
        step(1'b1, ST | ACK, ex(SL, 0, 1'b0, 0), "b_start");
        step(1'b1, ACK, ex(SW, 0, 1'b0, 0), "b_wait");
        step(1'b1, ST | ACK, ex(SW, 0, 1'b0, 0), "b_start_ignored");
        step(1'b1, ACK, ex(SW, 0, 1'b0, 0), "b_wait");
        step(1'b1, ACK, ex(SW, 0, 1'b0, 0), "b_wait");
        step(1'b1, ACK, ex(SN, 0, 1'b0, 0), "b_next");
        step(1'b1, ACK, ex(SL, 1, 1'b1, 0), "b_load1");
        step(1'b1, ACK, ex(SW, 1, 1'b0, 0), "b_wait1");
        step(1'b1, ACK, ex(SW, 1, 1'b0, 0), "b_wait1");
        rst_b = 1'b0;
        #1;
        check("b_async_reset", got(1'b1), ex(SI, 0, 1'b0, 0));
        step(1'b1, ST | ACK, ex(SI, 0, 1'b0, 0), "b_held_in_reset");
        rst_b = 1'b1;
        step(1'b1, ACK, ex(SI, 0, 1'b0, 0), "b_no_autostart");
        step(1'b1, ST, ex(SL, 0, 1'b0, 0), "b_restart");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
